uart_tx_frame_arbiter: RTL
==========================

# uart_tx_frame_arbiter

Shares one RS-232 byte transmitter among `N_REQ` byte-stream requesters. Each requester's packet is sent as one atomic frame: sync byte, requester ID, payload, then an 8-bit checksum. Grants rotate round-robin between frames. The block sits between the sensor/telemetry packetisers and the transmitter. It drives the transmitter's start/data inputs and watches its busy output.

## Interface
Parameters
- `N_REQ`, 4: number of requesters, 2..8.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports
- `clk`  in  1  system clock, shared with the transmitter.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  N_REQ  requester i has a payload byte on its slice of `req_data`.
- `req_data`  in  8*N_REQ  payload byte of requester i, in bits [8i+7:8i].
- `req_last`  in  N_REQ  the byte offered is the last one of the packet.
- `req_ready`  out  N_REQ  byte accepted this cycle when `req_valid[i] & req_ready[i]`.
- `grant`  out  N_REQ  one-hot owner of the current frame; all zeros when idle.
- `tx_start`  out  1  to the transmitter's start input. Registered; exactly 1-cycle pulses.
- `tx_data`  out  8  to the transmitter's data input. Registered; stable while `tx_start` is high.
- `tx_busy`  in  1  busy output of the transmitter.
- `frame_active`  out  1  a frame is in progress.
- `frame_count`  out  16  number of completed frames; wraps at 16'hFFFF to 0.

## Operation
- Frame phases: IDLE, SYNC, ID, DATA, CSUM.
- Within SYNC/ID/DATA/CSUM, each byte goes through the send sub-states ISSUE → STROBE → SETTLE.
  - ISSUE: wait for `tx_busy==0`.
    - In SYNC, ID and CSUM the byte is always available, so ISSUE leaves on `!tx_busy` alone.
    - In DATA, ISSUE also needs `req_valid[g]`.
    - On leaving ISSUE, register `tx_start<=1` and `tx_data<=byte`, then go to STROBE.
  - STROBE: `tx_start<=0`, then go to SETTLE.
  - SETTLE: wait one cycle (the transmitter's busy rises here), then go to ISSUE of the next byte or phase.
- IDLE:
  - If any `req_valid` is high, pick the granted index g by round-robin, searching from `last_g+1` modulo `N_REQ`.
  - Register g, `grant`, `frame_active<=1`, clear the checksum, and enter SYNC.
- Bytes sent per phase:
  - SYNC: sends `SYNC_BYTE`.
  - ID: sends `{5'b0, g}`.
  - DATA: `req_ready[g] = (phase==DATA && sub==ISSUE && !tx_busy)`, combinational.
    - On acceptance, send `req_data[g]` and update `csum <= csum + byte` (mod 256; payload bytes only).
    - If `req_last[g]` is set, the next phase is CSUM; otherwise stay in DATA.
  - CSUM: sends `csum`. After SETTLE:
    - `last_g<=g`, `grant<=0`, `frame_active<=0`, `frame_count++`;
    - go to IDLE.
- Atomicity: no other requester is granted until CSUM is issued. `req_ready` is never high for a non-granted index.
- Stall: if the owner drops `req_valid` mid-packet, stay in DATA/ISSUE indefinitely. The line idles (mark) between bytes, which is legal RS-232.
- Empty packet is not possible: a packet has at least 1 byte (the first byte may carry `req_last`).
- Reset values: `tx_start=0`, `tx_data=0`, `grant=0`, `req_ready=0`, `frame_active=0`, `frame_count=0`, `last_g=N_REQ-1` (so requester 0 wins first), phase IDLE.
- Reset mid-frame: the controller returns to IDLE immediately. The byte already inside the transmitter completes on its own; the next frame's ISSUE waits for `!tx_busy`.

## Timing
- IDLE with `req_valid` seen at edge e0 → SYNC/ISSUE at e1 → `tx_start` high in the cycle after e2 (if `tx_busy==0`).
- Per-byte controller overhead: 3 cycles (ISSUE→STROBE→SETTLE) plus the transmitter's busy time.
- The `tx_start` pulse is never issued while `tx_busy==1`, and never in two consecutive cycles.
- Requester byte acceptance coincides with the ISSUE cycle. `req_data` is captured in the same cycle.
- Frame of L payload bytes = L+3 transmitter bytes.

## Structure
- Shared package `uart_frame_pkg`: phase encoding, sub-state encoding, `SYNC_BYTE` default, `ID_WIDTH=3`.
- One sub-module: `rr_picker`, a combinational round-robin priority search over `N_REQ` with a `last_g` input, returning index plus found flag. Everything else lives in one sequential FSM.

## Test plan
- Single requester 0 sends {0x10,0x20(last)}, transmitter model busy for 20 cycles per byte → `tx_data` sequence A5,00,10,20,30; `frame_count`=1; each `tx_start` is exactly 1 cycle.
- Requesters 1 and 3 valid simultaneously after reset → frame order ID 01, then ID 03. Then with 1 and 3 again valid → 01 first again (`last_g`=3).
- Requester 2 mid-packet: requester 0 raises valid → no `req_ready[0]` until the CSUM of requester 2's frame has been sent.
- Owner drops `req_valid` for 50 cycles after the first byte → no `tx_start` during the gap; the frame resumes; checksum is correct.
- Payload {0xFF,0x02(last)} → CSUM 0x01 (mod-256 wrap).
- Assert `rst_n` during the DATA phase while `tx_busy=1` → outputs go to reset values asynchronously; after release, the next SYNC `tx_start` is issued only after `tx_busy` falls.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame arbiter: frame phase and per-byte send
// sub-state encodings, the default sync byte and the checksum helper.
package uart_frame_pkg;

    localparam int ID_WIDTH = 3;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_SYNC = 3'd1,
        PH_ID   = 3'd2,
        PH_DATA = 3'd3,
        PH_CSUM = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        SUB_ISSUE  = 2'd0,
        SUB_STROBE = 2'd1,
        SUB_SETTLE = 2'd2
    } sub_e;

    // Running frame checksum: modulo-256 sum of payload bytes.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_picker.sv
// Combinational round-robin search: first requesting index after last_g,
// wrapping modulo N_REQ, with a found flag.
module rr_picker
    import uart_frame_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ID_WIDTH-1:0] last_g,
    output logic [ID_WIDTH-1:0] idx,
    output logic                found
);

    logic hit_s;

    // Walk candidates last_g+1 .. last_g+N_REQ and keep the first one requesting.
    always_comb begin
        idx   = {ID_WIDTH{1'b0}};
        found = 1'b0;
        hit_s = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                hit_s = req[j] && !found && (j == ((int'(last_g) + k) % N_REQ));
                idx   = hit_s ? ID_WIDTH'(j) : idx;
                found = found | hit_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one byte transmitter among N_REQ requesters; each packet goes out as an
// atomic frame of sync byte, requester ID, payload and modulo-256 checksum.
module uart_tx_frame_arbiter
    import uart_frame_pkg::*;
#(
    parameter int         N_REQ     = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 frame_active,
    output logic [15:0]          frame_count
);

    localparam logic [ID_WIDTH-1:0] LAST_G_RESET = ID_WIDTH'(N_REQ - 1);

    phase_e                phase_r, phase_nxt_s;
    sub_e                  sub_r, sub_nxt_s;
    logic [ID_WIDTH-1:0]   g_r, g_nxt_s;
    logic [ID_WIDTH-1:0]   last_g_r, last_g_nxt_s;
    logic [N_REQ-1:0]      grant_r, grant_nxt_s;
    logic                  frame_active_r, frame_active_nxt_s;
    logic [15:0]           frame_count_r, frame_count_nxt_s;
    logic [7:0]            csum_r, csum_nxt_s;
    logic                  tx_start_r, tx_start_nxt_s;
    logic [7:0]            tx_data_r, tx_data_nxt_s;
    logic                  pkt_last_r, pkt_last_nxt_s;

    logic [ID_WIDTH-1:0]   pick_idx_s;
    logic                  pick_found_s;
    logic [N_REQ-1:0]      pick_onehot_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;
    logic [7:0]            sel_data_s;
    logic [7:0]            cur_byte_s;
    logic                  byte_ready_s;
    logic                  data_issue_s;
    logic [N_REQ-1:0]      req_ready_s;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req_valid),
        .last_g (last_g_r),
        .idx    (pick_idx_s),
        .found  (pick_found_s)
    );

    // Route the owner's valid/data/last and derive the one-hot form of the pick.
    always_comb begin
        sel_valid_s   = 1'b0;
        sel_last_s    = 1'b0;
        sel_data_s    = 8'h00;
        pick_onehot_s = {N_REQ{1'b0}};
        for (int j = 0; j < N_REQ; j++) begin
            sel_valid_s      = sel_valid_s | (req_valid[j] & (g_r == ID_WIDTH'(j)));
            sel_last_s       = sel_last_s | (req_last[j] & (g_r == ID_WIDTH'(j)));
            sel_data_s       = sel_data_s | (req_data[8*j +: 8] & {8{g_r == ID_WIDTH'(j)}});
            pick_onehot_s[j] = (pick_idx_s == ID_WIDTH'(j));
        end
    end

    // Byte offered in the current phase; payload bytes need the owner's valid.
    always_comb begin
        byte_ready_s = (phase_r != PH_DATA) | sel_valid_s;
        case (phase_r)
            PH_SYNC: cur_byte_s = SYNC_BYTE;
            PH_ID:   cur_byte_s = {{(8-ID_WIDTH){1'b0}}, g_r};
            PH_DATA: cur_byte_s = sel_data_s;
            PH_CSUM: cur_byte_s = csum_r;
            default: cur_byte_s = 8'h00;
        endcase
    end

    // Acceptance is combinational so the payload byte is captured in the ISSUE cycle.
    always_comb begin
        data_issue_s = (phase_r == PH_DATA) && (sub_r == SUB_ISSUE) && !tx_busy;
        req_ready_s  = {N_REQ{1'b0}};
        for (int j = 0; j < N_REQ; j++) begin
            req_ready_s[j] = data_issue_s && (g_r == ID_WIDTH'(j));
        end
    end

    // Frame FSM: next phase/sub-state and all registered outputs.
    always_comb begin
        phase_nxt_s        = phase_r;
        sub_nxt_s          = sub_r;
        g_nxt_s            = g_r;
        last_g_nxt_s       = last_g_r;
        grant_nxt_s        = grant_r;
        frame_active_nxt_s = frame_active_r;
        frame_count_nxt_s  = frame_count_r;
        csum_nxt_s         = csum_r;
        tx_start_nxt_s     = 1'b0;
        tx_data_nxt_s      = tx_data_r;
        pkt_last_nxt_s     = pkt_last_r;
        case (phase_r)
            PH_IDLE: begin
                if (pick_found_s) begin
                    g_nxt_s            = pick_idx_s;
                    grant_nxt_s        = pick_onehot_s;
                    frame_active_nxt_s = 1'b1;
                    csum_nxt_s         = 8'h00;
                    pkt_last_nxt_s     = 1'b0;
                    phase_nxt_s        = PH_SYNC;
                    sub_nxt_s          = SUB_ISSUE;
                end else begin
                    sub_nxt_s = SUB_ISSUE;
                end
            end
            PH_SYNC, PH_ID, PH_DATA, PH_CSUM: begin
                case (sub_r)
                    SUB_ISSUE: begin
                        if (!tx_busy && byte_ready_s) begin
                            tx_start_nxt_s = 1'b1;
                            tx_data_nxt_s  = cur_byte_s;
                            sub_nxt_s      = SUB_STROBE;
                            if (phase_r == PH_DATA) begin
                                csum_nxt_s     = csum_add(csum_r, sel_data_s);
                                pkt_last_nxt_s = sel_last_s;
                            end else begin
                                pkt_last_nxt_s = pkt_last_r;
                            end
                        end else begin
                            sub_nxt_s = SUB_ISSUE;
                        end
                    end
                    SUB_STROBE: begin
                        sub_nxt_s = SUB_SETTLE;
                    end
                    SUB_SETTLE: begin
                        // The transmitter's busy has risen by now, so ISSUE sees the real state.
                        sub_nxt_s = SUB_ISSUE;
                        case (phase_r)
                            PH_SYNC: phase_nxt_s = PH_ID;
                            PH_ID:   phase_nxt_s = PH_DATA;
                            PH_DATA: phase_nxt_s = pkt_last_r ? PH_CSUM : PH_DATA;
                            PH_CSUM: begin
                                last_g_nxt_s       = g_r;
                                grant_nxt_s        = {N_REQ{1'b0}};
                                frame_active_nxt_s = 1'b0;
                                frame_count_nxt_s  = frame_count_r + 16'd1;
                                phase_nxt_s        = PH_IDLE;
                            end
                            default: phase_nxt_s = PH_IDLE;
                        endcase
                    end
                    default: begin
                        sub_nxt_s = SUB_ISSUE;
                    end
                endcase
            end
            default: begin
                phase_nxt_s = PH_IDLE;
                sub_nxt_s   = SUB_ISSUE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r        <= PH_IDLE;
            sub_r          <= SUB_ISSUE;
            g_r            <= {ID_WIDTH{1'b0}};
            last_g_r       <= LAST_G_RESET;
            grant_r        <= {N_REQ{1'b0}};
            frame_active_r <= 1'b0;
            frame_count_r  <= 16'd0;
            csum_r         <= 8'h00;
            tx_start_r     <= 1'b0;
            tx_data_r      <= 8'h00;
            pkt_last_r     <= 1'b0;
        end else begin
            phase_r        <= phase_nxt_s;
            sub_r          <= sub_nxt_s;
            g_r            <= g_nxt_s;
            last_g_r       <= last_g_nxt_s;
            grant_r        <= grant_nxt_s;
            frame_active_r <= frame_active_nxt_s;
            frame_count_r  <= frame_count_nxt_s;
            csum_r         <= csum_nxt_s;
            tx_start_r     <= tx_start_nxt_s;
            tx_data_r      <= tx_data_nxt_s;
            pkt_last_r     <= pkt_last_nxt_s;
        end
    end

    assign req_ready    = req_ready_s;
    assign grant        = grant_r;
    assign tx_start     = tx_start_r;
    assign tx_data      = tx_data_r;
    assign frame_active = frame_active_r;
    assign frame_count  = frame_count_r;

endmodule
